// File: rtl/signal_types_pkg.sv
// Shared DAC sample types, loader FSM encoding and the offset-binary helper.
`default_nettype none

package signal_types_pkg;

    localparam int DAC_SAMPLE_W = 14;

    typedef struct packed {
        logic [DAC_SAMPLE_W-1:0] dac_ch1;
        logic [DAC_SAMPLE_W-1:0] dac_ch0;
    } dac_sample_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } loader_state_t;

    // Two's-complement 16-bit sample -> 14-bit offset binary (truncate LSBs, flip sign).
    function automatic logic [DAC_SAMPLE_W-1:0] to_offset_bin14(input logic [15:0] d);
        return {~d[15], d[14:2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_mem_loader.sv
// Streams packed dual-channel DAC samples into BRAM port A with auto-incrementing address.
// Optional: define DAC_LOADER_OFFSET_BIN_EN to convert signed 16-bit halves to 14-bit offset binary.
`default_nettype none

module dac_mem_loader
    import signal_types_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] count_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [31:0]           s_data_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output dac_sample_t           mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   wr_cnt_o
);

    loader_state_t         r_state;
    loader_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH:0]   r_wr_cnt;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    dac_sample_t           r_mem_wdata;
    logic                  r_done;
    logic                  r_err;

    logic                  w_in_load;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_start_ok;
    logic                  w_start_bad;
    logic                  w_busy;
    logic                  w_ready;
    dac_sample_t           w_packed;

    assign w_in_load   = (r_state == ST_LOAD);
    // A handshake coinciding with abort is dropped, even though ready is high.
    assign w_accept    = w_in_load && s_valid_i && !abort_i;
    assign w_last      = w_accept && ((r_wr_cnt + 1'b1) == {1'b0, r_count});
    assign w_start_ok  = !w_in_load && start_i && (count_i != '0);
    assign w_start_bad = !w_in_load && start_i && (count_i == '0);

`ifdef DAC_LOADER_OFFSET_BIN_EN
    logic w_unused_bits;
    assign w_unused_bits    = ^{s_data_i[17:16], s_data_i[1:0]};
    assign w_packed.dac_ch0 = to_offset_bin14(s_data_i[15:0]);
    assign w_packed.dac_ch1 = to_offset_bin14(s_data_i[31:16]);
`else
    logic w_unused_bits;
    assign w_unused_bits    = ^{s_data_i[31:30], s_data_i[15:14]};
    assign w_packed.dac_ch0 = s_data_i[13:0];
    assign w_packed.dac_ch1 = s_data_i[29:16];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_i || w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Ready is decoded from state only, so it never depends on s_valid_i.
    always_comb begin
        w_busy  = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_busy  = 1'b1;
                w_ready = 1'b1;
            end
            default: begin
                w_busy  = 1'b0;
                w_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_count     <= '0;
            r_wr_cnt    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= w_accept;
            if (w_accept) begin
                r_mem_addr  <= r_base + r_wr_cnt[ADDR_WIDTH-1:0];
                r_mem_wdata <= w_packed;
                r_wr_cnt    <= r_wr_cnt + 1'b1;
            end
            if (w_last) begin
                r_done <= 1'b1;
            end
            if (w_start_ok) begin
                r_base   <= base_addr_i;
                r_count  <= count_i;
                r_wr_cnt <= '0;
                r_done   <= 1'b0;
                r_err    <= 1'b0;
            end else if (w_start_bad || (w_in_load && (start_i || abort_i))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_ready_o   = w_ready;
    assign busy_o      = w_busy;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign wr_cnt_o    = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dac_mem_loader.sv
// Self-checking bench for dac_mem_loader: table-driven loads plus a write scoreboard.
`default_nettype none

module tb_dac_mem_loader;
    import signal_types_pkg::*;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [AW-1:0] count_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [31:0]   s_data_i = '0;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    dac_sample_t   mem_wdata_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   wr_cnt_o;

    dac_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .count_i(count_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .wr_cnt_o(wr_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [27:0]   data;
    } sb_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] count;
        logic [31:0]   dbase;
        logic [31:0]   dstep;
        logic [AW:0]   exp_wr_cnt;
        logic          exp_done;
    } vec_t;

    sb_t           sb[$];
    sb_t           mon_e;
    int            n_total = 0;
    int            n_pass = 0;
    logic [AW-1:0] exp_base;
    logic [AW-1:0] exp_idx;

    function automatic logic [27:0] exp_pack(input logic [31:0] d);
        logic [13:0] c0;
        logic [13:0] c1;
`ifdef DAC_LOADER_OFFSET_BIN_EN
        c0 = {~d[15], d[14:2]};
        c1 = {~d[31], d[30:18]};
`else
        c0 = d[13:0];
        c1 = d[29:16];
`endif
        return {c1, c0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each mem_we_o pulse must match the oldest outstanding accepted word.
    always @(negedge clk) begin
        if (rst_n && mem_we_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr_o), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr_o), 32'(mon_e.addr));
                chk("wr_data", 32'({mem_wdata_o.dac_ch1, mem_wdata_o.dac_ch0}), 32'(mon_e.data));
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
        start_i = 1'b1;
        base_addr_i = b;
        count_i = c;
        tick();
        start_i = 1'b0;
        exp_base = b;
        exp_idx = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input int gaps);
        sb_t e;
        for (int g = 0; g < gaps; g++) begin
            s_valid_i = 1'b0;
            tick();
        end
        s_valid_i = 1'b1;
        s_data_i = d;
        @(negedge clk);
        if (!s_ready_o) begin
            chk("ready_in_load", 32'(s_ready_o), 32'd1);
        end else begin
            e.addr = exp_base + exp_idx;
            e.data = exp_pack(d);
            sb.push_back(e);
            exp_idx = exp_idx + 1'b1;
        end
        tick();
    endtask

    task automatic run_load(input vec_t v, input int gapmax);
        logic [31:0] d;
        do_start(v.base, v.count);
        @(negedge clk);
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_clears", 32'({done_o, err_o, wr_cnt_o}), 32'd0);
        tick();
        d = v.dbase;
        for (int i = 0; i < int'(v.count); i++) begin
            send_word(d, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
            d = d + v.dstep;
        end
        s_valid_i = 1'b0;
        @(negedge clk);
        chk("end_done", 32'(done_o), 32'(v.exp_done));
        chk("end_wr_cnt", 32'(wr_cnt_o), 32'(v.exp_wr_cnt));
        chk("end_busy_ready", 32'({busy_o, s_ready_o}), 32'd0);
        chk("end_last_we", 32'(mem_we_o), 32'd1);
        chk("end_err", 32'(err_o), 32'd0);
        tick();
        @(negedge clk);
        chk("drained", 32'({mem_we_o, 1'b0} | 2'(sb.size() != 0)), 32'd0);
        tick();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{base: 11'h010, count: 11'd4, dbase: 32'h0001_0002, dstep: 32'h0001_0001, exp_wr_cnt: 12'd4, exp_done: 1'b1};
        vecs[1] = '{base: 11'h7FE, count: 11'd4, dbase: 32'h1234_5678, dstep: 32'h0101_0203, exp_wr_cnt: 12'd4, exp_done: 1'b1};
        vecs[2] = '{base: 11'h7FF, count: 11'd1, dbase: 32'hFFFF_FFFF, dstep: 32'h0, exp_wr_cnt: 12'd1, exp_done: 1'b1};
        vecs[3] = '{base: 11'h000, count: 11'd3, dbase: 32'h8000_7FFF, dstep: 32'h7FFF_8001, exp_wr_cnt: 12'd3, exp_done: 1'b1};
        vecs[4] = '{base: 11'h3A0, count: 11'd7, dbase: 32'hC3A5_5A3C, dstep: 32'h1357_2468, exp_wr_cnt: 12'd7, exp_done: 1'b1};

        #12;
        chk("reset_outs", 32'({s_ready_o, mem_we_o, busy_o, done_o, err_o}), 32'd0);
        chk("reset_wr_cnt", 32'(wr_cnt_o), 32'd0);
        chk("reset_mem", 32'({mem_addr_o, mem_wdata_o.dac_ch1, mem_wdata_o.dac_ch0}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_load(vecs[i], 0);

        // Abort while idle must leave status untouched.
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        chk("idle_abort", 32'({busy_o, done_o, err_o}), 32'b010);
        tick();

        // Zero-count start is rejected; done stays set.
        start_i = 1'b1;
        count_i = '0;
        base_addr_i = 11'h055;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("zero_cnt_err", 32'(err_o), 32'd1);
        chk("zero_cnt_idle", 32'({busy_o, s_ready_o}), 32'd0);
        chk("zero_cnt_done_kept", 32'(done_o), 32'd1);
        tick();
        run_load('{base: 11'h050, count: 11'd2, dbase: 32'h0ABC_0DEF, dstep: 32'h1, exp_wr_cnt: 12'd2, exp_done: 1'b1}, 2);

        // Gappy load with a stray start mid-load, then abort with a concurrent valid word.
        do_start(11'h200, 11'd8);
        send_word(32'h1111_2222, int'($urandom_range(0, 3)));
        send_word(32'h3333_4444, int'($urandom_range(0, 3)));
        s_valid_i = 1'b0;
        start_i = 1'b1;
        base_addr_i = 11'h400;
        count_i = 11'd5;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        chk("mid_start_err", 32'(err_o), 32'd1);
        chk("mid_start_busy", 32'(busy_o), 32'd1);
        tick();
        send_word(32'h5555_6666, int'($urandom_range(0, 3)));
        s_valid_i = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        s_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'({busy_o, s_ready_o, done_o, err_o}), 32'b0001);
        chk("abort_wr_cnt", 32'(wr_cnt_o), 32'd3);
        chk("abort_no_write", 32'({mem_we_o, 1'b0} | 2'(sb.size() != 0)), 32'd0);
        tick();

        // Asynchronous reset mid-load with a write pending.
        do_start(11'h100, 11'd6);
        send_word(32'h0102_0304, 0);
        send_word(32'h0506_0708, 0);
        s_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'({s_ready_o, mem_we_o, busy_o, done_o, err_o}), 32'd0);
        chk("async_rst_cnt", 32'(wr_cnt_o), 32'd0);
        chk("async_rst_mem", 32'({mem_addr_o, mem_wdata_o.dac_ch1, mem_wdata_o.dac_ch0}), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_load('{base: 11'h3F0, count: 11'd3, dbase: 32'h2000_1000, dstep: 32'h0010_0020, exp_wr_cnt: 12'd3, exp_done: 1'b1}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
